latch_writer: RTL and testbench
===============================

LATCH_WRITER -- requirements
Module: latch_writer

Interface
REQ-001 Parameter WIDTH, default 8: data width of the latch bank.
REQ-002 Parameter ADDR_W, default 2: address width; bank holds 2**ADDR_W latches.
REQ-003 Parameter SETUP_CYC, default 1: cycles lat_d is stable before the enable pulse; legal range is 1 or more.
REQ-004 Parameter PULSE_CYC, default 1: width of the enable pulse in cycles; legal range is 1 or more.
REQ-005 Parameter HOLD_CYC, default 1: cycles lat_d is held after the enable falls; legal range is 1 or more.
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  1  write request present.
REQ-009 req_ready  output  1  block can accept a request this cycle.
REQ-010 req_addr  input  ADDR_W  target latch index.
REQ-011 req_data  input  WIDTH  value to write.
REQ-012 lat_d  output  WIDTH  shared data bus to every latch d input.
REQ-013 lat_en  output  2**ADDR_W  one-hot latch enables (latch clk inputs).
REQ-014 busy  output  1  write sequence in progress.
REQ-015 done  output  1  one-cycle pulse at the end of each write.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, PULSE and HOLD.
REQ-017 A handshake SHALL occur when req_valid and req_ready are both high at a rising edge.
REQ-018 req_ready SHALL be high only in IDLE.
REQ-019 On a handshake, addr/data SHALL be captured and state SHALL go IDLE->SETUP.
REQ-020 SETUP SHALL last SETUP_CYC cycles, PULSE SHALL last PULSE_CYC cycles and HOLD SHALL last HOLD_CYC cycles, each timed by one shared down-counter reloaded on every state entry.
REQ-021 lat_d SHALL equal the captured data throughout SETUP, PULSE and HOLD, and SHALL retain its last value in IDLE.
REQ-022 lat_en SHALL be all-zero except in PULSE, where exactly bit captured_addr SHALL be high.
REQ-023 lat_en and lat_d SHALL be driven directly from flops (no combinational decode after the register), so the outputs are glitch-free toward the latches.
REQ-024 lat_d SHALL never change in the same cycle that any lat_en bit changes.
REQ-025 busy SHALL be high in SETUP, PULSE and HOLD.
REQ-026 done SHALL pulse high for one cycle in the final HOLD cycle; the state SHALL be IDLE with req_ready high in the following cycle.
REQ-027 Handshake-to-done latency SHALL be SETUP_CYC+PULSE_CYC+HOLD_CYC cycles; requests SHALL be spaced at least SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles apart.
REQ-028 req_valid held high while busy SHALL be ignored and not lost; it SHALL be accepted on the first IDLE cycle.
REQ-029 req_addr/req_data changes after the handshake SHALL have no effect on the write in progress.

Reset
REQ-030 When rst is asserted, the block SHALL asynchronously force state=IDLE, counter=0, lat_en=0, lat_d=0, busy=0, done=0 and captured addr/data=0.
REQ-031 Reset asserted mid-PULSE SHALL drop lat_en immediately without waiting for clk; the partially written latch content is undefined and is not required to be preserved.
REQ-032 req_ready SHALL be high in the first cycle after rst deasserts.

Structure
REQ-033 State encodings (IDLE=0, SETUP=1, PULSE=2, HOLD=3) and the phase counter width rule (clog2 of the largest *_CYC value, plus 1) SHALL live in a shared package, latch_pkg.
REQ-034 The phase down-counter SHALL be one sub-module, phase_timer, with inputs load, load_val and tick, and output zero.
REQ-035 No other sub-modules SHALL be used.

Verification
REQ-036 Defaults; rst pulse, then valid with addr=2, data=0xA5 -> lat_d=0xA5 from cycle 1; lat_en=4'b0100 only in cycle 2; done in cycle 3; ready high in cycle 4.
REQ-037 SETUP=2, PULSE=3, HOLD=2; addr=3, data=0x3C -> lat_en=4'b1000 for exactly 3 cycles; done at cycle 7 after the handshake.
REQ-038 req_valid held continuously with addr 0,1,2,3 and data 0x11,0x22,0x33,0x44 -> four writes spaced 4 cycles apart; each lat_en bit fires once, in order.
REQ-039 rst asserted in the middle of a PULSE cycle -> lat_en=0 and lat_d=0 before the next clk edge; req_ready=1 in the first cycle after release.
REQ-040 Bench of four dlatch instances driven by the block; write 0x5A to addr 1 -> only latch 1 q=0x5A; the other latches keep their prior values.
REQ-041 Random req_data/req_addr toggling while busy -> written value and address equal those captured at the handshake; lat_d never changes while any lat_en bit is high.

Source files
------------

// File: rtl/latch_pkg.sv
// ---------------------------------------------------------------------------
// latch_pkg
// Shared definitions for the latch bank writer.
//   state_t      : write-sequencer states with fixed encodings
//                  (IDLE=0, SETUP=1, PULSE=2, HOLD=3)
//   phase_cnt_w  : width of the shared phase down-counter, sized so the
//                  largest phase length minus one always fits, with one
//                  bit of headroom.
// ---------------------------------------------------------------------------
package latch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // clog2 of the longest phase plus one bit of headroom.
    function automatic int phase_cnt_w(input int setup_cyc,
                                       input int pulse_cyc,
                                       input int hold_cyc);
        int longest;
        longest = setup_cyc;
        if (pulse_cyc > longest) longest = pulse_cyc;
        if (hold_cyc > longest) longest = hold_cyc;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Down-counter that times one phase of the write sequence.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset, clears the count
//   load     : reload the count with load_val (takes priority over tick)
//   load_val : number of cycles remaining after the first cycle of a phase
//   tick     : decrement by one; the count saturates at zero
//   zero     : count is zero, i.e. the current cycle is the last one timed
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] count;

    // Reload on every phase entry, otherwise count down and stop at zero
    // so that an extra tick can never wrap the counter around.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/latch_writer.sv
// ---------------------------------------------------------------------------
// latch_writer
// Sequences writes into a bank of 2**ADDR_W level-sensitive latches that
// share one data bus. Each write presents the data for SETUP_CYC cycles,
// opens exactly one latch for PULSE_CYC cycles, then keeps the data stable
// for HOLD_CYC cycles after the latch closes.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   req_valid : write request present
//   req_ready : request can be accepted (high only while idle)
//   req_addr  : index of the latch to write
//   req_data  : value to write
//   lat_d     : shared data bus to every latch d input (flop output)
//   lat_en    : one-hot latch enables (flop outputs)
//   busy      : write sequence in progress
//   done      : one-cycle pulse in the final hold cycle of a write
// ---------------------------------------------------------------------------
module latch_writer
    import latch_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [WIDTH-1:0]      req_data,
    output logic [WIDTH-1:0]      lat_d,
    output logic [2**ADDR_W-1:0]  lat_en,
    output logic                  busy,
    output logic                  done
);

    localparam int NLAT = 2**ADDR_W;
    localparam int CW   = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    // The counter holds the cycles left after the current one, so a phase
    // of N cycles is loaded with N-1.
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
    // The last hold cycle is marked by the done flop rather than by the
    // counter, so that done can be a registered output. The counter
    // therefore only times the hold cycles before the last one.
    localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLD_CYC >= 2) ? HOLD_CYC - 2 : 0);

    state_t              state;
    logic [ADDR_W-1:0]   cap_addr;
    logic                handshake;
    logic                load;
    logic [CW-1:0]       load_val;
    logic                tick;
    logic                zero;

    assign handshake = req_valid & req_ready;

    // Timer control: reload on entry to each timed phase, otherwise tick
    // while the current phase still has cycles left.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        tick     = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    load     = 1'b1;
                    load_val = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (zero) begin
                    load     = 1'b1;
                    load_val = PULSE_LOAD;
                end else begin
                    tick = 1'b1;
                end
            end
            PULSE: begin
                if (zero) begin
                    load     = 1'b1;
                    load_val = HOLD_LOAD;
                end else begin
                    tick = 1'b1;
                end
            end
            HOLD: begin
                tick = ~zero;
            end
            default: begin
                tick = 1'b0;
            end
        endcase
    end

    phase_timer #(
        .W(CW)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .zero     (zero)
    );

    // Write sequencer with every output registered. lat_d doubles as the
    // captured data register: it is loaded at the handshake and held until
    // the next handshake, so it never moves while a latch is open. lat_en
    // only changes on the SETUP->PULSE and PULSE->HOLD edges, which are at
    // least one cycle away from any lat_d update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cap_addr  <= '0;
            lat_d     <= '0;
            lat_en    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        cap_addr  <= req_addr;
                        lat_d     <= req_data;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (zero) begin
                        lat_en <= NLAT'(1) << cap_addr;
                        state  <= PULSE;
                    end
                end
                PULSE: begin
                    if (zero) begin
                        lat_en <= '0;
                        done   <= (HOLD_CYC == 1);
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (done) begin
                        done      <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (zero) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_writer.sv
// ---------------------------------------------------------------------------
// tb_latch_writer
// Self-checking bench for latch_writer. A behavioural timeline model
// predicts every output from the handshake cycle and the phase lengths;
// accepted writes are queued and checked when the design pulses done,
// together with the contents of a small latch bank driven by the design.
// A second instance with longer phases gets a short directed check.
// ---------------------------------------------------------------------------
module tb_latch_writer;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 2;
    localparam int NLAT   = 4;
    localparam int S_CYC  = 1;
    localparam int P_CYC  = 1;
    localparam int H_CYC  = 1;
    localparam int LAT    = S_CYC + P_CYC + H_CYC;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
        int                done_cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [WIDTH-1:0]  req_data = '0;
    logic [WIDTH-1:0]  lat_d;
    logic [NLAT-1:0]   lat_en;
    logic              busy;
    logic              done;

    logic              b_valid = 1'b0;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [WIDTH-1:0]  b_data = '0;
    logic [WIDTH-1:0]  b_lat_d;
    logic [NLAT-1:0]   b_lat_en;
    logic              b_busy;
    logic              b_done;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    latch_writer u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .lat_d     (lat_d),
        .lat_en    (lat_en),
        .busy      (busy),
        .done      (done)
    );

    latch_writer #(
        .WIDTH     (WIDTH),
        .ADDR_W    (ADDR_W),
        .SETUP_CYC (2),
        .PULSE_CYC (3),
        .HOLD_CYC  (2)
    ) u_dut_long (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_addr  (b_addr),
        .req_data  (b_data),
        .lat_d     (b_lat_d),
        .lat_en    (b_lat_en),
        .busy      (b_busy),
        .done      (b_done)
    );

    // Latch bank fed by the main instance.
    logic [WIDTH-1:0] q [NLAT];
    for (genvar g = 0; g < NLAT; g++) begin : dlatch
        always_latch begin
            if (lat_en[g]) q[g] <= lat_d;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a write accepted at edge 'start' occupies cycles
    // start .. start+LAT-1, laid out as setup, pulse and hold windows.
    int                cyc = 0;
    int                start = -1;
    int                acc_cnt = 0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic [WIDTH-1:0]  cur_data = '0;
    logic [NLAT-1:0]   exp_en = '0;
    logic [WIDTH-1:0]  exp_d = '0;
    logic              exp_busy = 1'b0;
    logic              exp_done = 1'b0;
    logic              exp_ready = 1'b1;
    logic [WIDTH-1:0]  mmem [NLAT];
    logic              mvalid [NLAT] = '{default: 1'b0};
    wr_t               sb [$];

    always @(posedge clk) begin
        int off;
        cyc = cyc + 1;
        if (rst) begin
            if (start >= 0) mvalid[cur_addr] = 1'b0;
            start     = -1;
            exp_en    = '0;
            exp_d     = '0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            exp_ready = 1'b1;
        end else begin
            if (req_valid && exp_ready) begin
                start    = cyc;
                cur_addr = req_addr;
                cur_data = req_data;
                acc_cnt++;
                sb.push_back('{req_addr, req_data, cyc + LAT - 1});
            end
            off = (start >= 0) ? cyc - start + 1 : 0;
            if (off > LAT) begin
                start = -1;
                off   = 0;
            end
            exp_busy  = (off >= 1);
            exp_done  = (off == LAT);
            exp_ready = (off == 0);
            exp_en    = (off > S_CYC && off <= S_CYC + P_CYC) ? (NLAT'(1) << cur_addr) : '0;
            if (off == 1) exp_d = cur_data;
            if (off == LAT) begin
                mmem[cur_addr]   = cur_data;
                mvalid[cur_addr] = 1'b1;
            end
        end
    end

    // Monitor: per-cycle output checks, plus a scoreboard pop on each done.
    logic [NLAT-1:0]  prev_en = '0;
    logic [WIDTH-1:0] prev_d = '0;
    logic [NLAT-1:0]  seen_en = '0;
    int               pulse_len = 0;

    always @(negedge clk) begin
        wr_t w;
        if (rst) begin
            prev_en   = '0;
            prev_d    = '0;
            seen_en   = '0;
            pulse_len = 0;
            sb.delete();
        end else begin
            checkOutput("req_ready", req_ready, exp_ready);
            checkOutput("busy", busy, exp_busy);
            checkOutput("done", done, exp_done);
            checkOutput("lat_en", lat_en, exp_en);
            checkOutput("lat_d", lat_d, exp_d);
            if ((lat_en != prev_en) || (lat_en != '0))
                checkOutput("lat_d_stable_vs_en", lat_d, prev_d);
            if (lat_en != '0) begin
                seen_en = lat_en;
                pulse_len++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL done_unexpected: got done=1, expected no pending write at t=%0t", $time);
                end else begin
                    w = sb.pop_front();
                    checkOutput("write_addr_onehot", seen_en, NLAT'(1) << w.addr);
                    checkOutput("pulse_len", pulse_len, P_CYC);
                    checkOutput("write_data", lat_d, w.data);
                    checkOutput("done_cycle", cyc, w.done_cyc);
                    for (int i = 0; i < NLAT; i++)
                        if (mvalid[i]) checkOutput("latch_q", q[i], mmem[i]);
                end
                seen_en   = '0;
                pulse_len = 0;
            end
            prev_en = lat_en;
            prev_d  = lat_d;
        end
    end

    // Present one request and wait (bounded) until the model accepts it.
    task automatic applyStimulus(input logic [ADDR_W-1:0] a,
                                 input logic [WIDTH-1:0] d, input bit drop);
        int target;
        bit ok;
        target    = acc_cnt + 1;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        for (int k = 0; k < 3 * LAT + 5; k++) begin
            @(negedge clk);
            #1;
            if (acc_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: got no handshake, expected one for addr %0d", a);
        end
        if (drop) req_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Directed check of the long-phase instance: handshake in cycle 0.
    task automatic runLongPhase();
        int en_cnt, stray, done_at, done_cnt;
        en_cnt = 0; stray = 0; done_at = -1; done_cnt = 0;
        @(negedge clk);
        #1;
        checkOutput("long_ready_idle", b_ready, 1);
        b_valid = 1'b1;
        b_addr  = 2'd3;
        b_data  = 8'h3C;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (b_lat_en == 4'b1000) en_cnt++;
            else if (b_lat_en != '0) stray++;
            if (b_done) begin
                done_at = c;
                done_cnt++;
                checkOutput("long_data_at_done", b_lat_d, 8'h3C);
            end
            if (c == 1) checkOutput("long_ready_busy", b_ready, 0);
            if (c == 8) checkOutput("long_ready_after", b_ready, 1);
            #1;
            if (c == 1) begin
                b_valid = 1'b0;
                b_addr  = 2'd0;
                b_data  = 8'hFF;
            end
        end
        checkOutput("long_pulse_cycles", en_cnt, 3);
        checkOutput("long_stray_en", stray, 0);
        checkOutput("long_done_cycle", done_at, 7);
        checkOutput("long_done_count", done_cnt, 1);
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        // First write after reset, then a quiet gap.
        applyStimulus(2'd2, 8'hA5, 1'b1);
        idleCycles(6);

        // Valid held high across four back-to-back writes.
        applyStimulus(2'd0, 8'h11, 1'b0);
        applyStimulus(2'd1, 8'h22, 1'b0);
        applyStimulus(2'd2, 8'h33, 1'b0);
        applyStimulus(2'd3, 8'h44, 1'b1);
        idleCycles(6);

        // Single-latch write; the monitor checks the whole bank at done.
        applyStimulus(2'd1, 8'h5A, 1'b1);
        idleCycles(6);

        // Random traffic with inputs toggling every cycle, even while busy.
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = ADDR_W'($urandom_range(0, NLAT - 1));
            req_data  = WIDTH'($urandom);
        end
        req_valid = 1'b0;
        idleCycles(6);

        // Reset in the middle of a pulse cycle.
        applyStimulus(ADDR_W'($urandom_range(0, NLAT - 1)), WIDTH'($urandom_range(1, 255)), 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (exp_en != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pulse_wait_timeout: got no pulse window, expected one");
        end
        rst = 1'b1;
        #1;
        checkOutput("rst_lat_en", lat_en, 0);
        checkOutput("rst_lat_d", lat_d, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", req_ready, 1);
        idleCycles(3);
        applyStimulus(2'd0, 8'hC3, 1'b1);
        idleCycles(6);

        runLongPhase();

        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: got %0d writes still pending, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
